simt_stack_array: RTL and testbench
===================================

Name: simt_stack_array

Overview:
- Parametrised per-warp SIMT reconvergence stack array; successor to the fixed 8-warp/8-thread SIMT block.
- Sits between ID (two issue ports), WB (branch resolution) and ALU (PC+4 lookup).
- Holds SYNC/DIV/CALL tokens with PC and active mask per warp.
- Adds configurable warp count, thread width, depth and PC width, binary warp IDs, explicit empty/occupancy status, defined arbitration for same-warp collisions, and a WB-supplied divergence PC.

Parameters:
NUM_WARPS, 8, number of warps/stacks (>=2)
NUM_THREADS, 8, active-mask width
DEPTH, 4, entries per warp stack (>=2)
PC_W, 32, PC width
Localparams: WID_W=$clog2(NUM_WARPS), CNT_W=$clog2(DEPTH+1); tokens SYNC=2'b00, DIV=2'b01, CALL=2'b10.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
id0_valid  in  1  ID0 slot valid
id0_warp  in  WID_W  ID0 warp ID, binary
id0_branch / id0_call / id0_ret / id0_dots  in  1 each  ID0 instruction class flags
id0_pc_next  in  PC_W  ID0 PC+4
id0_ret_addr  in  PC_W  ID0 call return address
id0_mask  in  NUM_THREADS  ID0 active mask
id1_*  same set as id0_*, for ID slot 1
wb_valid  in  1  WB branch update
wb_warp  in  WID_W  WB warp ID
wb_pc  in  PC_W  PC for DIV entry (not-taken path)
wb_mask  in  NUM_THREADS  not-taken thread mask
alu_warp  in  WID_W  ALU lookup warp
alu_top_pc  out  PC_W  top PC of alu_warp
id0_top_pc / id1_top_pc  out  PC_W  top PC of idN_warp
id0_top_mask / id1_top_mask  out  NUM_THREADS  top mask of idN_warp
id0_top_div / id1_top_div  out  1  top token of idN_warp == DIV
full / empty / two_vacant  out  NUM_WARPS  per-warp count==DEPTH / count==0 / DEPTH-count>=2
err_overflow / err_underflow / err_conflict  out  1 each  sticky error flags

Behaviour:
- Reset: all counts 0 (empty=all 1, full=0, two_vacant=all 1), pending_dots=0, error flags 0; entry storage not reset.
- Top-of-stack outputs are combinational from the entry at count-1. When empty, they read 0 (top_div=0).
- Push/pop commits at the clock edge and is visible the next cycle.
- ID op decode, when idN_valid=1, in priority order:
  - branch: push {SYNC, pc_next, mask}; if dots also set, set pending_dots[warp].
  - else call: push {CALL, ret_addr, mask}.
  - else ret: pop.
  - else dots: pop (sync point).
  - else: no op.
- WB op, when wb_valid=1:
  - pending_dots[warp]=1 and wb_mask!=0: push {DIV, wb_pc, wb_mask}; clear pending.
  - pending_dots[warp]=1 and wb_mask==0: no stack op (no divergence); clear pending.
  - pending_dots[warp]=0: pop.
- Pending set and clear for the same warp in the same cycle: set wins.
- Collision: at most one stack op per warp per cycle, priority WB > ID0 > ID1. Losing ops are dropped and set err_conflict. Ops on different warps proceed in parallel, up to 3 per cycle.
- Push when full: dropped, count unchanged, err_overflow set.
- Pop when empty: dropped, err_underflow set.
- Counts stay within 0..DEPTH; there is no wrap-around.
- Reset asserted mid-operation clears state immediately, regardless of clock.

Optional Feature:
SIMT_STACK_ERR_EN
- Defined: err_overflow, err_underflow and err_conflict are sticky flags, cleared only by rst.
- Undefined: the three outputs are tied 0 and the error logic is removed. Drop/priority behaviour is unchanged.

Test Plan:
1. Reset, then id0 branch+dots warp 2, pc_next=0x104, mask=0xFF -> next cycle empty[2]=0, id0_top_pc=0x104 (id0_warp=2), top_div=0. Then wb warp 2, wb_pc=0x200, mask=0x0F -> count 2, top_div=1, top_pc=0x200, top_mask=0x0F.
2. WB warp 3 with pending_dots and wb_mask=0 -> count unchanged, pending cleared. Next WB warp 3 -> pop (underflow if empty, err_underflow=1).
3. DEPTH=4: five calls on warp 0 with ret_addr 0x10..0x50 -> full[0]=1 after four, fifth dropped, err_overflow=1, top_pc=0x40. Four rets -> empty[0]=1, alu_top_pc=0.
4. Same cycle, wb pop warp 1 plus id0 call warp 1 plus id1 call warp 5 -> warp 1 pops only, err_conflict=1, warp 5 pushes.
5. two_vacant tracking, DEPTH=4: counts 0,1,2,3 -> two_vacant 1,1,1,0; full asserts only at 4.
6. Assert rst mid-sequence with warp 0 at count 3 -> all empty=1 without a clock edge; errors 0.

Source files
------------

// File: rtl/simt_stack_array.sv
// simt_stack_array: per-warp SIMT reconvergence stacks of SYNC/DIV/CALL tokens, arbitrated WB > ID0 > ID1 per warp.
// Define SIMT_STACK_ERR_EN to build the sticky overflow/underflow/conflict flags; otherwise they are tied 0.
module simt_stack_array #(
    parameter int NUM_WARPS = 8,
    parameter int NUM_THREADS = 8,
    parameter int DEPTH = 4,
    parameter int PC_W = 32,
    localparam int WID_W = $clog2(NUM_WARPS),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id0_valid,
    input  logic [WID_W-1:0]       id0_warp,
    input  logic                   id0_branch,
    input  logic                   id0_call,
    input  logic                   id0_ret,
    input  logic                   id0_dots,
    input  logic [PC_W-1:0]        id0_pc_next,
    input  logic [PC_W-1:0]        id0_ret_addr,
    input  logic [NUM_THREADS-1:0] id0_mask,
    input  logic                   id1_valid,
    input  logic [WID_W-1:0]       id1_warp,
    input  logic                   id1_branch,
    input  logic                   id1_call,
    input  logic                   id1_ret,
    input  logic                   id1_dots,
    input  logic [PC_W-1:0]        id1_pc_next,
    input  logic [PC_W-1:0]        id1_ret_addr,
    input  logic [NUM_THREADS-1:0] id1_mask,
    input  logic                   wb_valid,
    input  logic [WID_W-1:0]       wb_warp,
    input  logic [PC_W-1:0]        wb_pc,
    input  logic [NUM_THREADS-1:0] wb_mask,
    input  logic [WID_W-1:0]       alu_warp,
    output logic [PC_W-1:0]        alu_top_pc,
    output logic [PC_W-1:0]        id0_top_pc,
    output logic [PC_W-1:0]        id1_top_pc,
    output logic [NUM_THREADS-1:0] id0_top_mask,
    output logic [NUM_THREADS-1:0] id1_top_mask,
    output logic                   id0_top_div,
    output logic                   id1_top_div,
    output logic [NUM_WARPS-1:0]   full,
    output logic [NUM_WARPS-1:0]   empty,
    output logic [NUM_WARPS-1:0]   two_vacant,
    output logic                   err_overflow,
    output logic                   err_underflow,
    output logic                   err_conflict
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] SYNC = 2'b00, DIV = 2'b01, CALL = 2'b10;

    typedef struct packed {
        logic [1:0]             tok;
        logic [PC_W-1:0]        pc;
        logic [NUM_THREADS-1:0] mask;
    } entry_t;

    // Source 0 = WB, 1 = ID0, 2 = ID1; lower index wins a same-warp collision.
    logic [2:0]           src_v;
    logic [2:0]           src_push;
    logic [WID_W-1:0]     src_w [3];
    entry_t               src_e [3];
    logic [NUM_WARPS-1:0] pending, pend_set, pend_clr;
    logic [NUM_WARPS-1:0] do_push, do_pop;
    entry_t               top [NUM_WARPS];

    always_comb begin
        src_v[0] = wb_valid && (!pending[wb_warp] || wb_mask != '0);
        src_push[0] = pending[wb_warp];
        src_w[0] = wb_warp;
        src_e[0] = '{tok: DIV, pc: wb_pc, mask: wb_mask};
        src_v[1] = id0_valid && (id0_branch || id0_call || id0_ret || id0_dots);
        src_push[1] = id0_branch || id0_call;
        src_w[1] = id0_warp;
        src_e[1] = '{tok: id0_branch ? SYNC : CALL, pc: id0_branch ? id0_pc_next : id0_ret_addr, mask: id0_mask};
        src_v[2] = id1_valid && (id1_branch || id1_call || id1_ret || id1_dots);
        src_push[2] = id1_branch || id1_call;
        src_w[2] = id1_warp;
        src_e[2] = '{tok: id1_branch ? SYNC : CALL, pc: id1_branch ? id1_pc_next : id1_ret_addr, mask: id1_mask};
        pend_set = '0;
        pend_clr = '0;
        if (id0_valid && id0_branch && id0_dots) pend_set[id0_warp] = 1'b1;
        if (id1_valid && id1_branch && id1_dots) pend_set[id1_warp] = 1'b1;
        if (wb_valid) pend_clr[wb_warp] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) pending <= '0;
        else pending <= (pending & ~pend_clr) | pend_set;

`ifdef SIMT_STACK_ERR_EN
    logic [NUM_WARPS-1:0] ovf, unf, col;
`endif

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        logic [2:0]       hit;
        logic [1:0]       s;
        logic [CNT_W-1:0] cnt;
        entry_t           ent [DEPTH];
        always_comb
            for (int k = 0; k < 3; k++) hit[k] = src_v[k] && src_w[k] == WID_W'(w);
        assign s = hit[0] ? 2'd0 : hit[1] ? 2'd1 : 2'd2;
        assign full[w] = cnt == CNT_W'(DEPTH);
        assign empty[w] = cnt == '0;
        assign two_vacant[w] = cnt <= CNT_W'(DEPTH - 2);
        assign do_push[w] = |hit && src_push[s] && !full[w];
        assign do_pop[w] = |hit && !src_push[s] && !empty[w];
        assign top[w] = empty[w] ? '0 : ent[AW'(cnt - 1'b1)];
`ifdef SIMT_STACK_ERR_EN
        assign ovf[w] = |hit && src_push[s] && full[w];
        assign unf[w] = |hit && !src_push[s] && empty[w];
        assign col[w] = (hit[0] && (hit[1] || hit[2])) || (hit[1] && hit[2]);
`endif
        always_ff @(posedge clk or posedge rst)
            if (rst) cnt <= '0;
            else if (do_push[w]) cnt <= cnt + 1'b1;
            else if (do_pop[w]) cnt <= cnt - 1'b1;
        // Entry storage is deliberately unreset; count alone defines validity.
        always_ff @(posedge clk)
            if (do_push[w]) ent[AW'(cnt)] <= src_e[s];
    end

    assign alu_top_pc = top[alu_warp].pc;
    assign id0_top_pc = top[id0_warp].pc;
    assign id1_top_pc = top[id1_warp].pc;
    assign id0_top_mask = top[id0_warp].mask;
    assign id1_top_mask = top[id1_warp].mask;
    assign id0_top_div = top[id0_warp].tok == DIV;
    assign id1_top_div = top[id1_warp].tok == DIV;

`ifdef SIMT_STACK_ERR_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            err_overflow <= 1'b0;
            err_underflow <= 1'b0;
            err_conflict <= 1'b0;
        end else begin
            err_overflow <= err_overflow || |ovf;
            err_underflow <= err_underflow || |unf;
            err_conflict <= err_conflict || |col;
        end
`else
    assign err_overflow = 1'b0;
    assign err_underflow = 1'b0;
    assign err_conflict = 1'b0;
`endif
endmodule

// File: tb/tb_simt_stack_array.sv
// tb_simt_stack_array: directed checks of push/pop, DIV insertion, arbitration, bounds and async reset.
module tb_simt_stack_array;
`ifdef SIMT_STACK_ERR_EN
    localparam logic E = 1'b1;
`else
    localparam logic E = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1;
    logic        id0_valid, id0_branch, id0_call, id0_ret, id0_dots;
    logic        id1_valid, id1_branch, id1_call, id1_ret, id1_dots;
    logic [2:0]  id0_warp = '0, id1_warp = '0, wb_warp = '0, alu_warp = '0;
    logic [31:0] id0_pc_next, id0_ret_addr, id1_pc_next, id1_ret_addr, wb_pc;
    logic [7:0]  id0_mask, id1_mask, wb_mask;
    logic        wb_valid;
    logic [31:0] alu_top_pc, id0_top_pc, id1_top_pc;
    logic [7:0]  id0_top_mask, id1_top_mask, full, empty, two_vacant;
    logic        id0_top_div, id1_top_div, err_overflow, err_underflow, err_conflict;
    int          n_cmp = 0, n_bad = 0;

    simt_stack_array dut (
        .clk(clk), .rst(rst),
        .id0_valid(id0_valid), .id0_warp(id0_warp), .id0_branch(id0_branch), .id0_call(id0_call),
        .id0_ret(id0_ret), .id0_dots(id0_dots), .id0_pc_next(id0_pc_next), .id0_ret_addr(id0_ret_addr),
        .id0_mask(id0_mask),
        .id1_valid(id1_valid), .id1_warp(id1_warp), .id1_branch(id1_branch), .id1_call(id1_call),
        .id1_ret(id1_ret), .id1_dots(id1_dots), .id1_pc_next(id1_pc_next), .id1_ret_addr(id1_ret_addr),
        .id1_mask(id1_mask),
        .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_pc(wb_pc), .wb_mask(wb_mask),
        .alu_warp(alu_warp), .alu_top_pc(alu_top_pc), .id0_top_pc(id0_top_pc), .id1_top_pc(id1_top_pc),
        .id0_top_mask(id0_top_mask), .id1_top_mask(id1_top_mask), .id0_top_div(id0_top_div),
        .id1_top_div(id1_top_div), .full(full), .empty(empty), .two_vacant(two_vacant),
        .err_overflow(err_overflow), .err_underflow(err_underflow), .err_conflict(err_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        {id0_valid, id0_branch, id0_call, id0_ret, id0_dots} = '0;
        {id1_valid, id1_branch, id1_call, id1_ret, id1_dots} = '0;
        {id0_pc_next, id0_ret_addr, id1_pc_next, id1_ret_addr, wb_pc} = '0;
        {id0_mask, id1_mask, wb_mask} = '0;
        wb_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1 clear();
        #1;
    endtask

    task automatic call0(input logic [2:0] w, input logic [31:0] ra);
        id0_valid = 1'b1; id0_call = 1'b1; id0_warp = w; id0_ret_addr = ra; id0_mask = 8'h0F;
    endtask

    task automatic wb_op(input logic [2:0] w, input logic [31:0] pc, input logic [7:0] m);
        wb_valid = 1'b1; wb_warp = w; wb_pc = pc; wb_mask = m;
    endtask

    initial begin
        clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_empty", empty, 8'hFF);
        check("rst_full", full, 8'h00);
        check("rst_two_vacant", two_vacant, 8'hFF);
        check("rst_err", {err_overflow, err_underflow, err_conflict}, 3'b000);
        check("rst_alu_pc", alu_top_pc, 0);

        // branch+dots on warp 2, then WB divergence push, then WB pop
        id0_valid = 1'b1; id0_warp = 3'd2; id0_branch = 1'b1; id0_dots = 1'b1;
        id0_pc_next = 32'h104; id0_mask = 8'hFF;
        tick();
        check("br_empty2", empty[2], 1'b0);
        check("br_pc", id0_top_pc, 32'h104);
        check("br_mask", id0_top_mask, 8'hFF);
        check("br_div", id0_top_div, 1'b0);
        wb_op(3'd2, 32'h200, 8'h0F);
        tick();
        check("div_flag", id0_top_div, 1'b1);
        check("div_pc", id0_top_pc, 32'h200);
        check("div_mask", id0_top_mask, 8'h0F);
        check("div_two_vac2", two_vacant[2], 1'b1);
        wb_op(3'd2, 32'h999, 8'hF0);
        tick();
        check("wb_pop_pc", id0_top_pc, 32'h104);
        check("wb_pop_div", id0_top_div, 1'b0);

        // warp 3: pending with zero mask -> no op; then pops and underflow
        id1_valid = 1'b1; id1_warp = 3'd3; id1_branch = 1'b1; id1_dots = 1'b1;
        id1_pc_next = 32'h300; id1_mask = 8'h33;
        tick();
        wb_op(3'd3, 32'h777, 8'h00);
        tick();
        check("nodiv_pc", id1_top_pc, 32'h300);
        check("nodiv_empty3", empty[3], 1'b0);
        wb_op(3'd3, 32'h0, 8'h01);
        tick();
        check("pop3_empty", empty[3], 1'b1);
        check("pop3_no_unf", err_underflow, 1'b0);
        wb_op(3'd3, 32'h0, 8'h01);
        tick();
        check("unf_flag", err_underflow, E);
        check("unf_empty3", empty[3], 1'b1);

        // warp 0 fill to DEPTH, overflow, drain
        alu_warp = 3'd0;
        for (int i = 1; i <= 4; i++) begin
            call0(3'd0, 32'(i * 16));
            tick();
            check($sformatf("fill%0d_pc", i), alu_top_pc, 32'(i * 16));
            check($sformatf("fill%0d_two_vac", i), two_vacant[0], i <= 2);
            check($sformatf("fill%0d_full", i), full[0], i == 4);
        end
        check("pre_ovf", err_overflow, 1'b0);
        call0(3'd0, 32'h50);
        tick();
        check("ovf_flag", err_overflow, E);
        check("ovf_full", full[0], 1'b1);
        check("ovf_pc", alu_top_pc, 32'h40);
        for (int i = 3; i >= 0; i--) begin
            id0_valid = 1'b1; id0_ret = 1'b1; id0_warp = 3'd0;
            tick();
            check($sformatf("ret%0d_pc", i), alu_top_pc, 32'(i * 16));
        end
        check("drain_empty0", empty[0], 1'b1);

        // collisions: WB beats ID0 on warp 1 while ID1 proceeds on warp 5
        call0(3'd1, 32'hA0);
        tick();
        call0(3'd1, 32'hB0);
        tick();
        check("pre_col", err_conflict, 1'b0);
        wb_op(3'd1, 32'h0, 8'h01);
        call0(3'd1, 32'hC0);
        id1_valid = 1'b1; id1_call = 1'b1; id1_warp = 3'd5; id1_ret_addr = 32'hD0; id1_mask = 8'h01;
        tick();
        check("col_w1_pc", id0_top_pc, 32'hA0);
        check("col_w5_pc", id1_top_pc, 32'hD0);
        check("col_w5_empty", empty[5], 1'b0);
        check("col_flag", err_conflict, E);
        call0(3'd6, 32'hE0);
        id1_valid = 1'b1; id1_call = 1'b1; id1_warp = 3'd6; id1_ret_addr = 32'hF0;
        tick();
        check("id_col_pc", id0_top_pc, 32'hE0);
        id1_valid = 1'b1; id1_dots = 1'b1; id1_warp = 3'd6;
        tick();
        check("dots_pop6", empty[6], 1'b1);

        // async reset with warp 0 at count 3
        for (int i = 1; i <= 3; i++) begin
            call0(3'd0, 32'(i * 17));
            tick();
        end
        check("pre_rst_two_vac", two_vacant[0], 1'b0);
        check("pre_rst_pc", alu_top_pc, 32'h33);
        #2 rst = 1'b1;
        #1;
        check("arst_empty", empty, 8'hFF);
        check("arst_full", full, 8'h00);
        check("arst_err", {err_overflow, err_underflow, err_conflict}, 3'b000);
        check("arst_alu_pc", alu_top_pc, 0);
        #10 rst = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
